// File: rtl/ee354_snake_pkg.sv
// Shared constants and encodings for the snake body tracker.
// The state encoding is one-hot to match the game state machine.
package ee354_snake_pkg;

  localparam int GRID     = 15;
  localparam int MAX_LEN  = GRID * GRID;
  localparam int INIT_LEN = 3;
  localparam int START_X  = 7;
  localparam int START_Y  = 7;

  localparam logic [3:0] COORD_MAX = 4'(GRID - 1);
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_MOVE  = 4'b0010,
    S_CHECK = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  // Opposite headings differ only in the upper bit of the encoding.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/ee354_snake_step.sv
// Combinational step logic: filters reversals, computes the next head cell
// and flags a step off the grid edge (coordinates never wrap).
module ee354_snake_step
  import ee354_snake_pkg::*;
(
  input  logic [1:0] heading,
  input  logic [1:0] dir,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  output logic [1:0] new_heading,
  output logic [3:0] next_x,
  output logic [3:0] next_y,
  output logic       wall
);

  always_comb begin
    new_heading = (dir == dir_opposite(heading)) ? heading : dir;
    next_x      = head_x;
    next_y      = head_y;
    wall        = 1'b0;
    unique case (new_heading)
      DIR_UP:    if (head_y == 4'd0)      wall = 1'b1; else next_y = head_y - 4'd1;
      DIR_RIGHT: if (head_x == COORD_MAX) wall = 1'b1; else next_x = head_x + 4'd1;
      DIR_DOWN:  if (head_y == COORD_MAX) wall = 1'b1; else next_y = head_y + 4'd1;
      default:   if (head_x == 4'd0)      wall = 1'b1; else next_x = head_x - 4'd1;
    endcase
  end

endmodule

// File: rtl/ee354_snake_body.sv
// Snake body tracker: segment store, one-cycle parallel shift, serial
// self-collision scan and a combinational renderer read port.
module ee354_snake_body
  import ee354_snake_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Run,
  input  logic       Tick,
  input  logic [1:0] Dir,
  input  logic [3:0] Food_X,
  input  logic [3:0] Food_Y,
  input  logic [7:0] Rd_Idx,
  output logic [3:0] Rd_X,
  output logic [3:0] Rd_Y,
  output logic       Rd_Valid,
  output logic [7:0] Length,
  output logic       Collision,
  output logic       Eat,
  output logic       Busy
);

  logic [3:0] seg_x [MAX_LEN];
  logic [3:0] seg_y [MAX_LEN];
  state_t     state, state_nx;
  logic [1:0] heading, step_heading;
  logic [3:0] step_x, step_y, nh_x, nh_y;
  logic       step_wall, grow, accept, scan_done, scan_hit;
  logic [7:0] k;

  ee354_snake_step u_step (
    .heading     (heading),
    .dir         (Dir),
    .head_x      (seg_x[0]),
    .head_y      (seg_y[0]),
    .new_heading (step_heading),
    .next_x      (step_x),
    .next_y      (step_y),
    .wall        (step_wall)
  );

  assign accept    = (state == S_IDLE) && Tick && Run;
  assign scan_done = (k >= Length);
  assign scan_hit  = !scan_done && (seg_x[k] == seg_x[0]) && (seg_y[k] == seg_y[0]);

  always_ff @(posedge Clk) begin
    if (Reset || Init) state <= S_IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = (state == S_MOVE) || (state == S_CHECK);
    unique case (state)
      S_IDLE:  if (accept) state_nx = step_wall ? S_HALT : S_MOVE;
      S_MOVE:  state_nx = S_CHECK;
      // A full board ends the round as a win rather than returning to play.
      S_CHECK: if (scan_done)     state_nx = (Length == LEN_MAX) ? S_HALT : S_IDLE;
               else if (scan_hit) state_nx = S_HALT;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? 4'(START_X - i) : 4'd0;
        seg_y[i] <= (i < INIT_LEN) ? 4'(START_Y) : 4'd0;
      end
      Length    <= 8'(INIT_LEN);
      heading   <= DIR_RIGHT;
      Collision <= 1'b0;
      Eat       <= 1'b0;
      grow      <= 1'b0;
      nh_x      <= 4'd0;
      nh_y      <= 4'd0;
      k         <= 8'd1;
    end else begin
      Eat <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          heading <= step_heading;
          if (step_wall) Collision <= 1'b1;
          else begin
            nh_x <= step_x;
            nh_y <= step_y;
            grow <= (step_x == Food_X) && (step_y == Food_Y) && (Length < LEN_MAX);
          end
        end
        S_MOVE: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          if (grow) begin
            Length <= Length + 8'd1;
            Eat    <= 1'b1;
          end
          k <= 8'd1;
        end
        // The vacated tail sits at index Length and is never compared.
        S_CHECK: if (!scan_done) begin
          if (scan_hit) Collision <= 1'b1;
          else          k <= k + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Rd_Valid = (Rd_Idx < Length);
    Rd_X     = 4'd0;
    Rd_Y     = 4'd0;
    if (Rd_Valid) begin
      Rd_X = seg_x[Rd_Idx];
      Rd_Y = seg_y[Rd_Idx];
    end
  end

endmodule
